// File: rtl/jk_pkg.sv
// Shared types and default sizing for the JK flip-flop Q-output monitor.
package jk_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HIT   = 2'd2
    } jk_state_e;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low clear.
// SYNC_STAGES must be 2 or more.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_r;

    // Shift the input through the synchroniser chain; reset empties it immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_r <= {SYNC_STAGES{1'b0}};
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/jk_q_monitor.sv
// Monitors the Q output of an upstream JK flip-flop: synchronises it, strobes
// rising/falling edges, keeps saturating edge counters and flags when the rise
// count reaches a programmable threshold.
module jk_q_monitor
    import jk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] threshold,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [WIDTH-1:0] rise_count,
    output logic [WIDTH-1:0] toggle_count,
    output logic             hit,
    output logic             overflow,
    output logic [1:0]       state_o
);

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic             q_sync_s;
    logic             run_s;
    logic             q_prev_r;
    jk_state_e        state_r;
    logic [WIDTH-1:0] rise_count_r;
    logic [WIDTH-1:0] toggle_count_r;
    logic             rise_pulse_r;
    logic             fall_pulse_r;
    logic             hit_r;
    logic             overflow_r;

    logic             armed_s;
    logic             rise_det_s;
    logic             fall_det_s;
    logic             any_det_s;
    logic             rise_at_max_s;
    logic             tog_at_max_s;
    logic             hit_match_s;
    logic             ovf_set_s;

    // q_in may be asynchronous to clk, so it is only used after this chain.
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (q_in),
        .q       (q_sync_s)
    );

    // Reset release is re-timed to clk; the FSM stays in IDLE until this
    // chain has filled, so edges in the first cycles after release are ignored.
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (1'b1),
        .q       (run_s)
    );

    // Previous synchronised level, tracked in every state so entering COUNT never sees a stale edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_prev_r <= 1'b0;
        end else begin
            q_prev_r <= q_sync_s;
        end
    end

    // Edge qualification, saturation and threshold-match decode.
    always_comb begin
        armed_s       = 1'b0;
        rise_det_s    = 1'b0;
        fall_det_s    = 1'b0;
        any_det_s     = 1'b0;
        rise_at_max_s = 1'b0;
        tog_at_max_s  = 1'b0;
        hit_match_s   = 1'b0;
        ovf_set_s     = 1'b0;

        armed_s       = (state_r == COUNT) || (state_r == HIT);
        rise_det_s    = armed_s && q_sync_s && !q_prev_r;
        fall_det_s    = armed_s && !q_sync_s && q_prev_r;
        any_det_s     = rise_det_s || fall_det_s;
        rise_at_max_s = (rise_count_r == CNT_MAX);
        tog_at_max_s  = (toggle_count_r == CNT_MAX);
        ovf_set_s     = (rise_det_s && rise_at_max_s) || (any_det_s && tog_at_max_s);

        // A zero threshold never matches; a saturated counter cannot increment into a match.
        if (rise_det_s && !rise_at_max_s && (threshold != CNT_ZERO)) begin
            hit_match_s = ((rise_count_r + CNT_ONE) == threshold);
        end else begin
            hit_match_s = 1'b0;
        end
    end

    // Monitor FSM with its counters, strobes and sticky flags; clear outranks any detected edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            rise_count_r   <= CNT_ZERO;
            toggle_count_r <= CNT_ZERO;
            rise_pulse_r   <= 1'b0;
            fall_pulse_r   <= 1'b0;
            hit_r          <= 1'b0;
            overflow_r     <= 1'b0;
        end else if (clear) begin
            state_r        <= IDLE;
            rise_count_r   <= CNT_ZERO;
            toggle_count_r <= CNT_ZERO;
            rise_pulse_r   <= 1'b0;
            fall_pulse_r   <= 1'b0;
            hit_r          <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            rise_pulse_r <= rise_det_s;
            fall_pulse_r <= fall_det_s;
            overflow_r   <= overflow_r || ovf_set_s;

            if (rise_det_s && !rise_at_max_s) begin
                rise_count_r <= rise_count_r + CNT_ONE;
            end else begin
                rise_count_r <= rise_count_r;
            end

            if (any_det_s && !tog_at_max_s) begin
                toggle_count_r <= toggle_count_r + CNT_ONE;
            end else begin
                toggle_count_r <= toggle_count_r;
            end

            case (state_r)
                IDLE: begin
                    hit_r <= 1'b0;
                    if (run_s && enable) begin
                        state_r <= COUNT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                COUNT: begin
                    if (hit_match_s) begin
                        state_r <= HIT;
                        hit_r   <= 1'b1;
                    end else if (!enable) begin
                        state_r <= IDLE;
                        hit_r   <= 1'b0;
                    end else begin
                        state_r <= COUNT;
                        hit_r   <= 1'b0;
                    end
                end
                HIT: begin
                    // Only clear or reset leave HIT; enable has no effect here.
                    state_r <= HIT;
                    hit_r   <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    hit_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rise_pulse   = rise_pulse_r;
    assign fall_pulse   = fall_pulse_r;
    assign rise_count   = rise_count_r;
    assign toggle_count = toggle_count_r;
    assign hit          = hit_r;
    assign overflow     = overflow_r;
    assign state_o      = state_r;

endmodule

// File: doc/jk_q_monitor.md
JK_Q_MONITOR -- requirements
Module: jk_q_monitor

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and threshold width.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the q_in synchroniser depth.
REQ-003 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 q_in  input  1  SHALL be the monitored Q output of the upstream JK flip-flop, which may be asynchronous to clk.
REQ-006 enable  input  1  SHALL arm edge counting when high.
REQ-007 clear  input  1  SHALL be a synchronous clear of counts, flags and FSM.
REQ-008 threshold  input  WIDTH  SHALL be the rise count at which hit asserts.
REQ-009 rise_pulse / fall_pulse  output  1 each  SHALL be one-cycle edge strobes.
REQ-010 rise_count  output  WIDTH  SHALL hold the accepted rising edges.
REQ-011 toggle_count  output  WIDTH  SHALL hold the accepted rising plus falling edges.
REQ-012 hit  output  1  SHALL be the sticky threshold-reached flag.
REQ-013 overflow  output  1  SHALL be the sticky saturation flag.
REQ-014 state_o  output  2  SHALL expose the FSM state: IDLE=0, COUNT=1, HIT=2.

Function
REQ-015 q_in SHALL pass through SYNC_STAGES flops to form q_sync before any other use.
REQ-016 q_prev SHALL register q_sync every cycle, in all states.
- In IDLE, q_prev tracking q_sync means no edge is ever reported on entry to COUNT.
REQ-017 An edge SHALL be detected when q_sync differs from q_prev; detection is qualified only in COUNT or HIT.
REQ-018 For a q_in change set up before clk edge k, rise_pulse or fall_pulse SHALL be high for exactly the cycle following edge k+SYNC_STAGES.
- Counts update on that same edge.
REQ-019 On each rising edge, rise_count SHALL increment by 1. On every edge, toggle_count SHALL increment by 1.
REQ-020 Both counters SHALL saturate at 2^WIDTH-1 and never wrap.
- An increment attempted at the maximum value SHALL set overflow.
REQ-021 FSM transitions:
- IDLE -> COUNT when enable=1.
- COUNT -> IDLE when enable=0; counts are held.
- COUNT -> HIT on the edge where the incremented rise_count equals threshold.
- HIT is left only by clear or reset; enable is ignored in HIT.
REQ-022 hit SHALL equal (state==HIT), registered on the same edge as the matching rise_count update.
REQ-023 threshold=0 SHALL never produce hit.
REQ-024 In HIT, edges SHALL still pulse and count, with saturation rules applied.
REQ-025 clear SHALL have these effects on the next edge:
- counters zeroed;
- hit and overflow zeroed;
- FSM to IDLE;
- pulses suppressed.
REQ-026 clear coincident with an edge detection SHALL win; no pulse is produced and the counters read 0.
REQ-027 threshold SHALL be sampled only at compare time. A change to a value already below rise_count SHALL NOT assert hit.

Reset
REQ-028 While reset_n=0, every flop SHALL be 0 immediately, independent of clk:
- synchroniser stages, q_prev, counters, pulses, hit, overflow;
- state=IDLE.
REQ-029 Reset deassertion SHALL be synchronised to clk before it reaches the FSM.
- Edges seen during the first SYNC_STAGES cycles after release SHALL NOT be counted.
REQ-030 Reset asserted mid-count SHALL discard all counts; no partial pulse SHALL appear.

Structure
REQ-031 The package jk_pkg SHALL hold the state enum (IDLE, COUNT, HIT) and default constants for WIDTH and SYNC_STAGES.
REQ-032 The synchroniser SHALL be the single sub-module sync_bit (parameter SYNC_STAGES), reused for q_in.
- All other logic is flat in jk_q_monitor.

Verification
REQ-033 Reset release with q_in=1 and enable=1 -> no rise_pulse; rise_count=0.
REQ-034 enable=1, threshold=3, four q_in 0->1->0 cycles -> state as follows:
- rise_count=4, toggle_count=8, hit=1;
- hit rises with the 3rd rise_pulse;
- state_o=2.
REQ-035 Single q_in rise before edge k -> rise_pulse high only in the cycle after edge k+2 (SYNC_STAGES=2).
REQ-036 WIDTH=4, 20 toggles:
- toggle_count=15, rise_count=10;
- overflow=1 from the 16th toggle.
REQ-037 clear asserted in the same cycle as a detected edge -> no pulse, counters=0, hit=0, state_o=0.
REQ-038 reset_n pulsed low mid-count, asynchronous to clk -> all outputs 0 within the same cycle; counting resumes from 0 after re-enable.
